// File: rtl/sonar_pkg.sv
// rtl/sonar_pkg.sv - shared state encoding and timing defaults for the sonar driver
package sonar_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HOLDOFF   = 3'd1,
    S_TRIG      = 3'd2,
    S_WAIT_RISE = 3'd3,
    S_MEASURE   = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  localparam logic [7:0] DIST_TIMEOUT = 8'hFF;

  localparam int DEF_CLK_FREQ_HZ    = 50_000_000;
  localparam int DEF_TRIG_CYCLES    = 500;
  localparam int DEF_CYCLES_PER_CM  = 2900;
  localparam int DEF_TIMEOUT_CYCLES = 1_900_000;
  localparam int DEF_HOLDOFF_CYCLES = 3_000_000;

endpackage

// File: rtl/sonar_driver_echo_sync.sv
// rtl/sonar_driver_echo_sync.sv - echo pin synchroniser with registered edge pulses
module sonar_driver_echo_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic echo_i,
  output logic rise_o,
  output logic fall_o
);

  // sync_q[1:0] is the two-flop synchroniser, sync_q[2] holds the previous synchronised level
  logic [2:0] sync_q;
  logic       rise_q;
  logic       fall_q;

  // Shift the raw echo through the synchroniser and register one-cycle edge pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 3'b000;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], echo_i};
      rise_q <= sync_q[1] & ~sync_q[2];
      fall_q <= ~sync_q[1] & sync_q[2];
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/sonar_driver.sv
// rtl/sonar_driver.sv - HC-SR04 style ranger: trigger pulse, echo timing, cm conversion
module sonar_driver
  import sonar_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = DEF_CLK_FREQ_HZ,
  parameter int TRIG_CYCLES    = CLK_FREQ_HZ / 100_000,
  parameter int CYCLES_PER_CM  = DEF_CYCLES_PER_CM,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       measure_i,
  output logic       ready_o,
  output logic [7:0] distance_o,
  output logic       trig_o,
  input  logic       echo_i
);

  // One timer serves both the trigger width and the echo timeouts
  localparam int TMAX = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam int SW   = $clog2(CYCLES_PER_CM);
  localparam int HW   = $clog2(HOLDOFF_CYCLES);

  localparam logic [TW-1:0] TRIG_LAST    = TW'(TRIG_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SUB_LAST     = SW'(CYCLES_PER_CM - 1);
  localparam logic [HW-1:0] HOLD_LAST    = HW'(HOLDOFF_CYCLES - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [7:0]    cm_q, cm_d;
  logic [HW-1:0] holdoff_q, holdoff_d;
  logic          pending_q, pending_d;
  logic          ready_q, ready_d;
  logic [7:0]    dist_q, dist_d;
  logic [7:0]    result_q, result_d;
  logic          trig_q, trig_d;
  logic          echo_rise, echo_fall;

  sonar_driver_echo_sync u_echo_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .echo_i (echo_i),
    .rise_o (echo_rise),
    .fall_o (echo_fall)
  );

  // Next-state logic; MEASURE counts its own cycle, so the fall cycle is included in the width
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    sub_d     = sub_q;
    cm_d      = cm_q;
    pending_d = pending_q;
    ready_d   = ready_q;
    dist_d    = dist_q;
    result_d  = result_q;
    holdoff_d = (holdoff_q != '0) ? holdoff_q - 1'b1 : holdoff_q;

    case (state_q)
      S_IDLE: begin
        if (measure_i || pending_q) begin
          ready_d = 1'b0;
          if (holdoff_q == '0) begin
            state_d   = S_TRIG;
            timer_d   = '0;
            pending_d = 1'b0;
          end else begin
            state_d   = S_HOLDOFF;
            pending_d = 1'b1;
          end
        end
      end
      S_HOLDOFF: begin
        if (holdoff_q == '0) begin
          state_d   = S_TRIG;
          timer_d   = '0;
          pending_d = 1'b0;
        end
      end
      S_TRIG: begin
        if (timer_q == TRIG_LAST) begin
          state_d = S_WAIT_RISE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_RISE: begin
        if (echo_rise) begin
          state_d = S_MEASURE;
          timer_d = '0;
          sub_d   = '0;
          cm_d    = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d  = S_DONE;
          result_d = DIST_TIMEOUT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_MEASURE: begin
        if (sub_q == SUB_LAST) begin
          sub_d = '0;
          cm_d  = (cm_q == 8'hFF) ? cm_q : cm_q + 8'd1;
        end else begin
          sub_d = sub_q + 1'b1;
        end
        if (echo_fall) begin
          state_d  = S_DONE;
          result_d = cm_d;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d  = S_DONE;
          result_d = DIST_TIMEOUT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: begin
        dist_d    = result_q;
        ready_d   = 1'b1;
        holdoff_d = HOLD_LAST;
        state_d   = S_IDLE;
        if (measure_i) pending_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    trig_d = (state_d == S_TRIG);
  end

  // State and datapath registers; reset drops trig immediately
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      sub_q     <= '0;
      cm_q      <= '0;
      holdoff_q <= '0;
      pending_q <= 1'b0;
      ready_q   <= 1'b1;
      dist_q    <= DIST_TIMEOUT;
      result_q  <= DIST_TIMEOUT;
      trig_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sub_q     <= sub_d;
      cm_q      <= cm_d;
      holdoff_q <= holdoff_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      dist_q    <= dist_d;
      result_q  <= result_d;
      trig_q    <= trig_d;
    end
  end

  assign ready_o    = ready_q;
  assign distance_o = dist_q;
  assign trig_o     = trig_q;

endmodule

// File: tb/tb_sonar_driver.sv
// tb/tb_sonar_driver.sv - self-checking bench for sonar_driver
module tb_sonar_driver;

  localparam int TRIG    = 5;
  localparam int CPM     = 10;
  localparam int TMO     = 400;
  localparam int HOLD    = 50;
  localparam int TMO_BIG = 5000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       measure = 1'b0;
  logic       echo = 1'b0;
  logic       ready;
  logic [7:0] distance;
  logic       trig;

  logic       measure2 = 1'b0;
  logic       echo2 = 1'b0;
  logic       ready2;
  logic [7:0] distance2;
  logic       trig2;

  int n_assert = 0;
  int n_fail   = 0;
  int trig_rises = 0;
  logic trig_prev = 1'b0;

  always #5 clk = ~clk;

  sonar_driver #(
    .TRIG_CYCLES(TRIG), .CYCLES_PER_CM(CPM), .TIMEOUT_CYCLES(TMO), .HOLDOFF_CYCLES(HOLD)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .measure_i(measure), .ready_o(ready),
    .distance_o(distance), .trig_o(trig), .echo_i(echo)
  );

  sonar_driver #(
    .TRIG_CYCLES(TRIG), .CYCLES_PER_CM(CPM), .TIMEOUT_CYCLES(TMO_BIG), .HOLDOFF_CYCLES(HOLD)
  ) u_sat (
    .clk_i(clk), .rst_i(rst), .measure_i(measure2), .ready_o(ready2),
    .distance_o(distance2), .trig_o(trig2), .echo_i(echo2)
  );

  always @(negedge clk) begin
    if (trig && !trig_prev) trig_rises = trig_rises + 1;
    trig_prev = trig;
  end

  // Reference: echo width in cycles -> floor cm, saturating, or timeout code
  function automatic logic [7:0] model_cm(input int n, input int cpm, input int tmo);
    int q;
    if (n == 0 || n > tmo) return 8'hFF;
    q = n / cpm;
    return (q > 255) ? 8'd255 : q[7:0];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_measure(input int n_echo, input int pre, input bit spam,
                            input logic [7:0] exp, input string tag,
                            output int trig_wait, output int ready_wait);
    int w;
    int rises0;
    rises0 = trig_rises;
    measure = 1'b1;
    tick(1);
    measure = 1'b0;
    check({tag, "_ready_low"}, ready, 1'b0);
    w = 0;
    while (!trig && w < 200) begin tick(1); w++; end
    trig_wait = w;
    check({tag, "_trig_seen"}, trig, 1'b1);
    w = 0;
    while (trig && w < 50) begin w++; tick(1); end
    check({tag, "_trig_width"}, w, TRIG);
    if (spam) measure = 1'b1;
    tick(pre);
    measure = 1'b0;
    if (n_echo > 0) begin
      echo = 1'b1;
      tick(n_echo);
      echo = 1'b0;
    end
    w = 0;
    while (!ready && w < 6000) begin tick(1); w++; end
    ready_wait = w;
    check({tag, "_ready_back"}, ready, 1'b1);
    check({tag, "_distance"}, distance, exp);
    check({tag, "_one_trig"}, trig_rises - rises0, 1);
  endtask

  task automatic sat_measure(input int n_echo, input logic [7:0] exp, input string tag);
    int w;
    measure2 = 1'b1;
    tick(1);
    measure2 = 1'b0;
    w = 0;
    while (!trig2 && w < 200) begin tick(1); w++; end
    while (trig2 && w < 400) begin tick(1); w++; end
    tick(3);
    echo2 = 1'b1;
    tick(n_echo);
    echo2 = 1'b0;
    w = 0;
    while (!ready2 && w < 6000) begin tick(1); w++; end
    check({tag, "_ready"}, ready2, 1'b1);
    check({tag, "_distance"}, distance2, exp);
  endtask

  initial begin
    int tw;
    int rw;
    int n;
    tick(2);
    check("rst_ready", ready, 1'b1);
    check("rst_distance", distance, 8'hFF);
    check("rst_trig", trig, 1'b0);
    rst = 1'b0;
    tick(2);

    do_measure(235, 3, 1'b0, model_cm(235, CPM, TMO), "echo235", tw, rw);
    check("first_trig_immediate", tw, 0);
    do_measure(9, 2, 1'b0, model_cm(9, CPM, TMO), "echo9", tw, rw);

    tick(HOLD + 2);
    do_measure(0, 0, 1'b0, 8'hFF, "no_echo", tw, rw);
    check("no_echo_timeout_cycles", rw, TMO + 1);

    tick(HOLD + 2);
    do_measure(3000, 3, 1'b0, model_cm(3000, CPM, TMO), "long_echo", tw, rw);
    sat_measure(3000, model_cm(3000, CPM, TMO_BIG), "sat255");
    tick(HOLD + 2);
    sat_measure(2545, model_cm(2545, CPM, TMO_BIG), "sat254");

    tick(HOLD + 2);
    do_measure(120, 4, 1'b0, model_cm(120, CPM, TMO), "pre_holdoff", tw, rw);
    tick(10);
    do_measure(77, 4, 1'b1, model_cm(77, CPM, TMO), "holdoff", tw, rw);
    check("holdoff_gap", 10 + 1 + tw, HOLD);

    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(1, 395);
      do_measure(n, $urandom_range(0, 20), 1'($urandom_range(0, 1)),
                 model_cm(n, CPM, TMO), "random", tw, rw);
    end

    measure = 1'b1;
    tick(1);
    measure = 1'b0;
    n = 0;
    while (!trig && n < 200) begin tick(1); n++; end
    while (trig && n < 300) begin tick(1); n++; end
    tick(3);
    echo = 1'b1;
    tick(50);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_trig", trig, 1'b0);
    check("rst_mid_ready", ready, 1'b1);
    check("rst_mid_distance", distance, 8'hFF);
    tick(2);
    echo = 1'b0;
    rst = 1'b0;
    tick(2);

    measure = 1'b1;
    tick(1);
    measure = 1'b0;
    tick(1);
    check("trig_before_async_rst", trig, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("rst_in_trig_drops", trig, 1'b0);
    tick(1);
    rst = 1'b0;
    tick(2);
    do_measure(235, 3, 1'b0, model_cm(235, CPM, TMO), "after_rst", tw, rw);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
